// File: rtl/rv_word_responder_pkg.sv
// Shared types and limits for the RV half-word toggle-handshake responder.
package rv_word_responder_pkg;

  localparam int unsigned RV_RESP_LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } rv_resp_state_t;

endpackage

// File: rtl/rv_word_responder_bram.sv
// Single-port 16-bit synchronous RAM with byte write enables and registered read data.
module rv_bram_16 #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           din,
  output logic [15:0]           dout
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [15:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we[0]) mem[addr][7:0] <= din[7:0];
      if (we[1]) mem[addr][15:8] <= din[15:8];
      if (we == 2'b00) dout <= mem[addr];
    end
  end

endmodule

// File: rtl/rv_word_responder.sv
// BRAM-backed responder for the RV bridge 16-bit toggle handshake, with programmable ack latency.
module rv_word_responder
  import rv_word_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rv_req,
  output logic                  rv_req_ack,
  input  logic [ADDR_WIDTH-1:0] rv_addr,
  input  logic                  rv_we,
  input  logic [15:0]           rv_din,
  input  logic [1:0]            rv_ds,
  output logic [15:0]           rv_dout,
  output logic                  busy,
  output logic                  overrun
);

  if (LATENCY < 1 || LATENCY > RV_RESP_LATENCY_MAX) begin : gen_latency_check
    $error("rv_word_responder: LATENCY must be within 1..%0d", RV_RESP_LATENCY_MAX);
  end

  localparam logic [3:0] LatLoad = 4'(LATENCY - 1);

  rv_resp_state_t state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [15:0]           din_q;
  logic [1:0]            ds_q;
  logic                  req_q;
  logic                  req_prev_q;
  logic                  ack_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic [15:0]           dout_q;
  logic                  ram_en;
  logic [1:0]            ram_we;
  logic [15:0]           ram_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (rv_req != ack_q) begin
          capture = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = LatLoad;
        state_d = (LatLoad == 4'd0) ? ACK : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // ACK is a one-cycle state, so leave WAIT as the count reaches zero.
        if (cnt_q == 4'd1) state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      din_q      <= 16'h0000;
      ds_q       <= 2'b00;
      req_q      <= 1'b0;
      req_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      dout_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_prev_q <= rv_req;
      if (capture) begin
        addr_q <= rv_addr;
        we_q   <= rv_we;
        din_q  <= rv_din;
        ds_q   <= rv_ds;
        req_q  <= rv_req;
        busy_q <= 1'b1;
      end
      if (state_q == ACK) begin
        ack_q  <= req_q;
        busy_q <= 1'b0;
        if (!we_q) dout_q <= ram_q;
      end
      if (busy_q && (rv_req != req_prev_q)) overrun_q <= 1'b1;
    end
  end

  assign ram_en = (state_q == ACCESS);
  assign ram_we = (ram_en && we_q) ? ds_q : 2'b00;

  rv_bram_16 #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_bram (
    .clk (clk),
    .en  (ram_en),
    .we  (ram_we),
    .addr(addr_q),
    .din (din_q),
    .dout(ram_q)
  );

  assign rv_req_ack = ack_q;
  assign rv_dout    = dout_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/rv_word_responder.md
# rv_word_responder

Responder end of the 16-bit toggle-handshake port that the iosys RV bridge uses to split 32-bit softcore accesses into two half-word requests. It serves that port from on-chip block RAM instead of SDRAM, for fast scratch/WRAM shadow regions, with a programmable response latency. This lets bridge and software be exercised without the SDRAM controller. It sits between the RV bridge state machine and a private byte-enabled BRAM.

## Interface
Parameters:
- ADDR_WIDTH, 12, half-word address width; memory depth is 2**ADDR_WIDTH words of 16 bits.
- LATENCY, 2, cycles between BRAM access and ack toggle; legal range 1..15, elaboration error outside it.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rv_req  in  1  request toggle; a new request is pending while rv_req != rv_req_ack.
- rv_req_ack  out  1  acknowledge toggle; set equal to rv_req when the request completes.
- rv_addr  in  ADDR_WIDTH  half-word address; bit 0 selects the lower or upper half of a 32-bit word.
- rv_we  in  1  1 = write, 0 = read.
- rv_din  in  16  write data.
- rv_ds  in  2  byte strobes for writes; [1] = bits 15:8, [0] = bits 7:0; ignored on reads.
- rv_dout  out  16  read data; held until the next read completes.
- busy  out  1  high from request capture until ack.
- overrun  out  1  sticky; rv_req changed while busy. Cleared only by reset.

## Operation
- States: IDLE, ACCESS, WAIT, ACK.
- IDLE: if rv_req != rv_req_ack, capture addr, we, din, ds and rv_req, set busy, go to ACCESS.
- ACCESS: one BRAM cycle.
  - Write: update only the bytes whose rv_ds bit is 1. ds=00 changes nothing but still acks.
  - Read: issue the address.
  - Load the counter with LATENCY-1 and go to WAIT.
- WAIT: decrement the counter. When it is 0, go to ACK.
- ACK: toggle rv_req_ack to the captured rv_req value and clear busy.
  - Read: load rv_dout from BRAM on the same edge.
  - Write: rv_dout is unchanged.
  - Return to IDLE.
- The input fields are sampled only at capture, so the initiator may change them after the ack.
- Overrun: an rv_req edge while busy sets overrun. The in-flight request still completes with its captured data. The extra toggle is then judged by parity only:
  - an odd number of extra toggles makes a further request pending after the ack;
  - an even number is lost.
- Address wrap: no range check. The full ADDR_WIDTH is used and the top address is valid.
- Memory contents are not reset and are undefined after configuration.

## Timing
- Reset values: rv_req_ack=0, rv_dout=0, busy=0, overrun=0, state IDLE.
- Let E0 be the capture edge:
  - E1: BRAM write commits, or the read address is issued.
  - E(1+LATENCY): rv_req_ack toggles, rv_dout becomes valid, busy falls.
- rv_dout is stable from the ack edge onward. The initiator may sample it on any later cycle, up to the completion edge of the next read.
- Back-to-back: a request already pending at the ack edge is captured at E(2+LATENCY). Minimum period is LATENCY+2 cycles.
- A read that follows a write to the same address returns the new data.
- If rv_req=1 on the first edge after reset deassertion, a request is captured on that edge.
- Reset asserted mid-request:
  - before E1: the write is not committed;
  - at or after E1: it is committed;
  - in either case no ack is issued, and outputs return to their reset values immediately.

## Structure
- Shared package: the rv_resp_state_t enum (IDLE/ACCESS/WAIT/ACK) and the constant RV_RESP_LATENCY_MAX = 15.
- Sub-module rv_bram_16: single-port synchronous RAM with 16-bit words, byte write enables and registered read data, inferable as Gowin BSRAM.
- Top of the block: FSM, capture registers, latency counter and overrun detector.

## Test plan
- Reset, then write 0xBEEF to address 0x005 with ds=11, then read it back: ack toggles at E0+3 (LATENCY=2) and rv_dout=0xBEEF on the read's ack edge.
- Byte strobes: write 0x1234 (ds=11), then 0xAB00 (ds=10), then 0x00CD (ds=00); the read returns 0xAB34.
- Two halves of one 32-bit read issued in the bridge pattern: the second request is toggled the cycle after the first ack, and both complete with a LATENCY+2 cycle spacing.
- Set LATENCY=1 and issue a read; ack toggles exactly 2 edges after capture. With LATENCY=15, ack comes at 16.
- Toggle rv_req twice while busy: overrun=1, exactly one ack occurs, and no further request follows. With three toggles, a second request follows.
- Assert resetn during ACCESS of a write to 0x0FFF: rv_req_ack=0 and busy=0 immediately, and a later read of 0x0FFF returns the committed data.
